jstk_disp_filter: RTL and testbench
===================================

Name: jstk_disp_filter

Overview:
Upstream stage of the seven-segment debug display path. Takes raw 10-bit joystick X/Y samples from the SPI receiver. Runs a per-axis power-of-two boxcar moving average. Selects one axis and presents a registered, freeze-able 10-bit value with a valid strobe to the display controller's binary input.

Parameters:
- DATA_W, 10, sample and output width.
- AVG_LOG2, 3, log2 of the averaging window depth. Window = 8 samples. Legal range 1..4.
- DEADBAND, 16, half-width of the snap-to-centre band. Used only with the optional feature.

Ports:
- DCLK input 1: clock.
- RST input 1: reset, synchronous, active-high.
- SAMPLE_VALID input 1: one-cycle strobe; SAMPLE_X/SAMPLE_Y are valid.
- SAMPLE_X input DATA_W: raw X axis sample.
- SAMPLE_Y input DATA_W: raw Y axis sample.
- SEL input 1: axis select. 0 = X, 1 = Y.
- FREEZE input 1: level. Hold DOUT while high.
- DOUT output DATA_W: averaged value of the selected axis.
- DOUT_VALID output 1: one-cycle pulse when DOUT takes a new value.
- PRIMED output 1: high once the first sample since reset has been absorbed.

Behaviour:
- Reset values:
  - DOUT=0, DOUT_VALID=0, PRIMED=0.
  - All window entries = 0, running sums = 0.
  - FSM = S_PRIME.
- RST has priority over every other input in the same cycle.
- Per-axis storage:
  - Window is a shift register of 2^AVG_LOG2 entries.
  - Running sum is DATA_W+AVG_LOG2 bits wide (13 at defaults), so it never overflows.
  - Average = sum >> AVG_LOG2, truncating.
- FSM states: S_PRIME, S_RUN, S_FROZEN.
- S_PRIME:
  - On SAMPLE_VALID, every window entry of each axis is preloaded with that axis sample.
  - Sum is set to sample << AVG_LOG2.
  - PRIMED goes to 1 on the next cycle.
  - Next state is S_RUN, or S_FROZEN if FREEZE=1.
- S_RUN:
  - On SAMPLE_VALID (cycle n): sum <= sum + new - oldest, and the window shifts (cycle n+1).
  - DOUT <= average of the selected axis at cycle n+2, with DOUT_VALID=1 for exactly that cycle.
  - Latency is 2 cycles from strobe to DOUT.
- SEL change in S_RUN/S_PRIMED with no sample:
  - DOUT reloads from the other axis average one cycle after the change.
  - DOUT_VALID pulses.
  - If a sample-driven update and a SEL-driven reload coincide, one reload occurs with one pulse, using the new SEL.
- FREEZE=1:
  - Go to S_FROZEN; DOUT is held and DOUT_VALID=0.
  - Averaging continues internally on every SAMPLE_VALID.
- FREEZE falling while in S_FROZEN:
  - Go to S_RUN.
  - DOUT reloads the current average of the selected axis on the next cycle, with a DOUT_VALID pulse.
- FREEZE=1 in S_PRIME:
  - Priming still occurs.
  - DOUT stays 0 until FREEZE is released.
- SAMPLE_VALID back-to-back on consecutive cycles is legal. Each sample is absorbed, with no drops.
- SAMPLE_VALID while RST=1 is ignored.

Optional Feature:
- Macro: JSTK_DEADBAND_EN.
- When defined: before DOUT is registered, an average within [512-DEADBAND, 512+DEADBAND] (inclusive) is replaced by 512, the centre value. Latency is unchanged; the comparison is combinational inside the same register stage.
- When undefined: there is no deadband logic, and the DEADBAND parameter is unused.

Decomposition:
- Package jstk_disp_pkg holds:
  - DATA_W.
  - The state enum typedef (S_PRIME, S_RUN, S_FROZEN).
  - CENTER_VAL = 10'd512.
  - The sum width function DATA_W+AVG_LOG2.
- Sub-module jstk_axis_avg:
  - Holds one axis window, running sum, priming and average output.
  - Instantiated twice, once for X and once for Y.
- The top level holds the FSM, the select/freeze mux, the optional deadband and the output register.

Test Plan:
1. RST=1 for 3 cycles, then release with no samples: DOUT=0, DOUT_VALID=0, PRIMED=0 held indefinitely.
2. Priming and select:
   - SEL=0, strobe X=400, Y=600: DOUT=400 with DOUT_VALID 2 cycles later, and PRIMED=1.
   - Then set SEL=1: DOUT=600 with a pulse 1 cycle later.
3. Window fill:
   - After priming at X=400, strobe X=800 eight times, SEL=0.
   - DOUT sequence must be 450, 500, 550, 600, 650, 700, 750, 800, one pulse per sample.
4. Freeze:
   - Raise FREEZE, then strobe five X=0 samples: DOUT holds and no pulses occur.
   - Drop FREEZE: DOUT equals the current average (e.g. 300 from the 800-primed window: (3×800)/8 = 300) with one pulse.
5. Full scale: prime and feed X=1023 ×8, back-to-back strobes. DOUT=1023, no wrap, every strobe produces a pulse.
6. Reset mid-run:
   - Assert RST during a window update: all outputs return to reset values.
   - The next strobe X=100 re-primes, giving DOUT=100.
   - With JSTK_DEADBAND_EN defined, strobe X=520: DOUT=512. Strobe X=529: DOUT=529.

Source files
------------

// File: rtl/jstk_disp_filter_pkg.sv
// Shared types and constants for the joystick display filter path.
// Optional build macro: JSTK_DEADBAND_EN (snap-to-centre on the displayed value).
package jstk_disp_pkg;

    // Sample and output width of the whole path.
    localparam int DATA_W = 10;

    // Mid-scale value that the deadband snaps to.
    localparam logic [DATA_W-1:0] CENTER_VAL = 10'd512;

    // Display FSM states.
    typedef enum logic [1:0] {
        S_PRIME  = 2'd0,
        S_RUN    = 2'd1,
        S_FROZEN = 2'd2
    } state_t;

    // Running-sum width: wide enough for a full window of full-scale samples.
    function automatic int sum_width(input int avg_log2);
        return DATA_W + avg_log2;
    endfunction

endpackage

// File: rtl/jstk_disp_filter_if.sv
// Bus between the SPI receiver / display controller and the filter.
// Optional build macro: JSTK_DEADBAND_EN (no effect on this interface).
interface jstk_disp_filter_if;
    import jstk_disp_pkg::*;

    logic              SAMPLE_VALID;
    logic [DATA_W-1:0] SAMPLE_X;
    logic [DATA_W-1:0] SAMPLE_Y;
    logic              SEL;
    logic              FREEZE;
    logic [DATA_W-1:0] DOUT;
    logic              DOUT_VALID;
    logic              PRIMED;

    // Upstream side: supplies samples and display controls.
    modport master (
        output SAMPLE_VALID, SAMPLE_X, SAMPLE_Y, SEL, FREEZE,
        input  DOUT, DOUT_VALID, PRIMED
    );

    // Filter side.
    modport slave (
        input  SAMPLE_VALID, SAMPLE_X, SAMPLE_Y, SEL, FREEZE,
        output DOUT, DOUT_VALID, PRIMED
    );

endinterface

// File: rtl/jstk_disp_filter_axis_avg.sv
// One-axis boxcar moving average: window shift register plus running sum.
// Optional build macro: JSTK_DEADBAND_EN (not used in this file).
module jstk_axis_avg
    import jstk_disp_pkg::*;
#(
    parameter int AVG_LOG2 = 3
) (
    input  logic              DCLK,
    input  logic              RST,
    input  logic              i_en,
    input  logic              i_prime,
    input  logic [DATA_W-1:0] i_sample,
    output logic [DATA_W-1:0] o_avg
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = sum_width(AVG_LOG2);

    logic [DATA_W-1:0] r_win      [DEPTH];
    logic [DATA_W-1:0] w_win_next [DEPTH];
    logic [SUM_W-1:0]  r_sum;
    logic [SUM_W-1:0]  w_sum_next;

    // Entry 0 always takes the new sample; older entries shift down, or are
    // all preloaded with the sample while priming so the average starts flat.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_win
            if (gi == 0) begin : g_head
                assign w_win_next[gi] = i_sample;
            end else begin : g_tail
                assign w_win_next[gi] = i_prime ? i_sample : r_win[gi-1];
            end
        end
    endgenerate

    // Priming loads a full window's worth; otherwise add newest, drop oldest.
    // The sum always covers the oldest entry, so the subtraction cannot wrap.
    assign w_sum_next = i_prime
                      ? (SUM_W'(i_sample) << AVG_LOG2)
                      : (r_sum + SUM_W'(i_sample) - SUM_W'(r_win[DEPTH-1]));

    // Window and sum advance together on every accepted sample.
    always_ff @(posedge DCLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) r_win[i] <= '0;
            r_sum <= '0;
        end else if (i_en) begin
            for (int i = 0; i < DEPTH; i++) r_win[i] <= w_win_next[i];
            r_sum <= w_sum_next;
        end
    end

    // Truncating divide by the window depth.
    assign o_avg = r_sum[SUM_W-1:AVG_LOG2];

endmodule

// File: rtl/jstk_disp_filter.sv
// Joystick display filter top: two axis averagers, axis select, freeze,
// optional deadband and the registered display output.
// Optional build macro: JSTK_DEADBAND_EN enables snap-to-centre around 512.
module jstk_disp_filter
    import jstk_disp_pkg::*;
#(
    parameter int AVG_LOG2 = 3
`ifdef JSTK_DEADBAND_EN
    ,
    parameter int DEADBAND = 16
`endif
) (
    input  logic               DCLK,
    input  logic               RST,
    jstk_disp_filter_if.slave  bus
);

    state_t            r_state;
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_valid;
    logic              r_primed;
    logic              r_pend;
    logic              r_sel_prev;

    logic              w_prime;
    logic [DATA_W-1:0] w_avg_x;
    logic [DATA_W-1:0] w_avg_y;
    logic [DATA_W-1:0] w_avg_sel;
    logic [DATA_W-1:0] w_disp;

    assign w_prime = (r_state == S_PRIME);

    jstk_axis_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_x (
        .DCLK     (DCLK),
        .RST      (RST),
        .i_en     (bus.SAMPLE_VALID),
        .i_prime  (w_prime),
        .i_sample (bus.SAMPLE_X),
        .o_avg    (w_avg_x)
    );

    jstk_axis_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_y (
        .DCLK     (DCLK),
        .RST      (RST),
        .i_en     (bus.SAMPLE_VALID),
        .i_prime  (w_prime),
        .i_sample (bus.SAMPLE_Y),
        .o_avg    (w_avg_y)
    );

    assign w_avg_sel = bus.SEL ? w_avg_y : w_avg_x;

`ifdef JSTK_DEADBAND_EN
    // Averages close to mid-scale are shown as exactly mid-scale.
    assign w_disp = ((int'(w_avg_sel) >= int'(CENTER_VAL) - DEADBAND) &&
                     (int'(w_avg_sel) <= int'(CENTER_VAL) + DEADBAND))
                  ? CENTER_VAL : w_avg_sel;
`else
    assign w_disp = w_avg_sel;
`endif

    // Display FSM: r_pend marks that the sums moved on the previous edge, so
    // the output register picks up the new average one edge later. A select
    // change reloads immediately; both together give a single reload.
    always_ff @(posedge DCLK) begin
        if (RST) begin
            r_state      <= S_PRIME;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_primed     <= 1'b0;
            r_pend       <= 1'b0;
            r_sel_prev   <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            r_sel_prev   <= bus.SEL;
            case (r_state)
                S_PRIME: begin
                    if (bus.SAMPLE_VALID) begin
                        r_primed <= 1'b1;
                        r_pend   <= ~bus.FREEZE;
                        r_state  <= bus.FREEZE ? S_FROZEN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.FREEZE) begin
                        r_pend  <= 1'b0;
                        r_state <= S_FROZEN;
                    end else begin
                        r_pend <= bus.SAMPLE_VALID;
                        if (r_pend || (bus.SEL != r_sel_prev)) begin
                            r_dout       <= w_disp;
                            r_dout_valid <= 1'b1;
                        end
                    end
                end
                S_FROZEN: begin
                    r_pend <= 1'b0;
                    if (!bus.FREEZE) begin
                        r_state      <= S_RUN;
                        r_dout       <= w_disp;
                        r_dout_valid <= 1'b1;
                        r_pend       <= bus.SAMPLE_VALID;
                    end
                end
                default: begin
                    r_state <= S_PRIME;
                    r_pend  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DOUT       = r_dout;
    assign bus.DOUT_VALID = r_dout_valid;
    assign bus.PRIMED     = r_primed;

endmodule

// File: tb/tb_jstk_disp_filter.sv
// Directed self-checking bench for jstk_disp_filter.
// Optional build macro: JSTK_DEADBAND_EN (bench adds snap-to-centre checks).
module tb_jstk_disp_filter;
    import jstk_disp_pkg::*;

    logic DCLK;
    logic RST;
    int   n_checks;
    int   n_fail;
    int   pulse_cnt;
    logic [DATA_W-1:0] pulse_q[$];

    jstk_disp_filter_if bus_if ();

    jstk_disp_filter dut (
        .DCLK (DCLK),
        .RST  (RST),
        .bus  (bus_if)
    );

    initial DCLK = 1'b0;
    always #5 DCLK = ~DCLK;

    // Log every output pulse, sampled mid-cycle.
    always @(negedge DCLK) begin
        if (bus_if.DOUT_VALID === 1'b1) begin
            pulse_cnt++;
            pulse_q.push_back(bus_if.DOUT);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("  ok %s: %0d", tag, obs);
        end
    endtask

    // Expected displayed value for a given average.
    function automatic logic [31:0] disp_of(input int v);
`ifdef JSTK_DEADBAND_EN
        if (v >= 496 && v <= 528) return 32'd512;
`endif
        return v;
    endfunction

    task automatic tick();
        @(posedge DCLK);
        #1;
    endtask

    // Single strobe then one idle cycle: output visible after the second edge.
    task automatic strobe2(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
        bus_if.SAMPLE_VALID = 1'b1;
        bus_if.SAMPLE_X     = x;
        bus_if.SAMPLE_Y     = y;
        tick();
        bus_if.SAMPLE_VALID = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    int fill_exp [8] = '{450, 500, 550, 600, 650, 700, 750, 800};
    int full_exp [9] = '{0, 127, 255, 383, 511, 639, 767, 895, 1023};
    int p0;

    initial begin
        n_checks = 0; n_fail = 0; pulse_cnt = 0;
        bus_if.SAMPLE_VALID = 1'b0;
        bus_if.SAMPLE_X = '0;
        bus_if.SAMPLE_Y = '0;
        bus_if.SEL = 1'b0;
        bus_if.FREEZE = 1'b0;
        RST = 1'b1;
        repeat (3) tick();
        RST = 1'b0;

        // 1: idle after reset
        repeat (10) tick();
        check_val("idle_dout", bus_if.DOUT, 0);
        check_val("idle_valid", bus_if.DOUT_VALID, 0);
        check_val("idle_primed", bus_if.PRIMED, 0);
        check_val("idle_pulses", pulse_cnt, 0);

        // 2: priming, latency, select
        bus_if.SAMPLE_VALID = 1'b1; bus_if.SAMPLE_X = 10'd400; bus_if.SAMPLE_Y = 10'd600;
        tick();
        bus_if.SAMPLE_VALID = 1'b0;
        check_val("prime_primed", bus_if.PRIMED, 1);
        check_val("prime_valid_n1", bus_if.DOUT_VALID, 0);
        tick();
        check_val("prime_dout", bus_if.DOUT, 400);
        check_val("prime_valid_n2", bus_if.DOUT_VALID, 1);
        bus_if.SEL = 1'b1;
        tick();
        check_val("sel_y_dout", bus_if.DOUT, 600);
        check_val("sel_y_valid", bus_if.DOUT_VALID, 1);
        tick();
        check_val("sel_y_single", bus_if.DOUT_VALID, 0);

        // 3: window fill on X
        bus_if.SEL = 1'b0;
        tick();
        check_val("sel_x_dout", bus_if.DOUT, 400);
        tick();
        p0 = pulse_cnt;
        for (int i = 0; i < 8; i++) begin
            strobe2(10'd800, 10'd600);
            check_val($sformatf("fill_%0d_dout", i), bus_if.DOUT, disp_of(fill_exp[i]));
            check_val($sformatf("fill_%0d_valid", i), bus_if.DOUT_VALID, 1);
        end
        tick();
        check_val("fill_pulses", pulse_cnt - p0, 8);

        // 4: freeze holds, release reloads current average
        bus_if.FREEZE = 1'b1;
        tick();
        p0 = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            strobe2(10'd0, 10'd600);
            check_val($sformatf("frz_%0d_dout", i), bus_if.DOUT, 800);
        end
        check_val("frz_pulses", pulse_cnt - p0, 0);
        bus_if.FREEZE = 1'b0;
        tick();
        check_val("unfrz_dout", bus_if.DOUT, 300);
        check_val("unfrz_valid", bus_if.DOUT_VALID, 1);
        tick();
        check_val("unfrz_pulses", pulse_cnt - p0, 1);

        // 5: full scale, back-to-back strobes
        do_reset();
        tick();
        pulse_q.delete();
        bus_if.SAMPLE_VALID = 1'b1; bus_if.SAMPLE_X = 10'd0; bus_if.SAMPLE_Y = 10'd0;
        tick();
        bus_if.SAMPLE_X = 10'd1023;
        repeat (8) tick();
        bus_if.SAMPLE_VALID = 1'b0;
        repeat (4) tick();
        check_val("full_pulses", pulse_q.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < pulse_q.size())
                check_val($sformatf("full_%0d", i), pulse_q[i], disp_of(full_exp[i]));
        end
        check_val("full_dout", bus_if.DOUT, 1023);

        // 6: reset during an update, then re-prime
        bus_if.SAMPLE_VALID = 1'b1; bus_if.SAMPLE_X = 10'd500;
        tick();
        RST = 1'b1; bus_if.SAMPLE_X = 10'd900;
        tick();
        check_val("rst_dout", bus_if.DOUT, 0);
        check_val("rst_valid", bus_if.DOUT_VALID, 0);
        check_val("rst_primed", bus_if.PRIMED, 0);
        RST = 1'b0; bus_if.SAMPLE_VALID = 1'b0;
        tick();
        check_val("rst_hold_dout", bus_if.DOUT, 0);
        check_val("rst_hold_primed", bus_if.PRIMED, 0);
        strobe2(10'd100, 10'd0);
        check_val("reprime_dout", bus_if.DOUT, 100);
        check_val("reprime_primed", bus_if.PRIMED, 1);
        strobe2(10'd900, 10'd0);
        check_val("reprime_next", bus_if.DOUT, 200);

`ifdef JSTK_DEADBAND_EN
        do_reset();
        strobe2(10'd520, 10'd0);
        check_val("db_520", bus_if.DOUT, 512);
        do_reset();
        strobe2(10'd528, 10'd0);
        check_val("db_528", bus_if.DOUT, 512);
        do_reset();
        strobe2(10'd529, 10'd0);
        check_val("db_529", bus_if.DOUT, 529);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
